// File: rtl/magia_tile_stdio_mon.sv
// Passive AXI4 write-channel snooper: pairs AW descriptors with W beats, turns
// stdout writes into a buffered character stream and the first stderr write into an exit code.
module magia_tile_stdio_mon #(
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          MaxOutstanding = 8,
  parameter int unsigned          CharFifoDepth  = 16,
  parameter logic [AddrWidth-1:0] StdoutAddr     = 32'hFFFF0004,
  parameter logic [AddrWidth-1:0] StderrAddr     = 32'hFFFF0000
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              aw_valid_i,
  input  logic                              aw_ready_i,
  input  logic [AddrWidth-1:0]              aw_addr_i,
  input  logic [7:0]                        aw_len_i,
  input  logic                              w_valid_i,
  input  logic                              w_ready_i,
  input  logic [DataWidth-1:0]              w_data_i,
  input  logic [DataWidth/8-1:0]            w_strb_i,
  input  logic                              w_last_i,
  output logic                              char_valid_o,
  output logic [7:0]                        char_o,
  input  logic                              char_ready_i,
  output logic                              eoc_o,
  output logic [31:0]                       exit_code_o,
  output logic                              err_o,
  output logic [15:0]                       dropped_o,
  output logic [$clog2(MaxOutstanding):0]   outstanding_o
);

  localparam int unsigned DPW = $clog2(MaxOutstanding);
  localparam int unsigned DCW = DPW + 1;
  localparam int unsigned CPW = $clog2(CharFifoDepth);
  localparam int unsigned CCW = CPW + 1;

  typedef enum logic [1:0] {CLS_OTHER = 2'd0, CLS_STDOUT = 2'd1, CLS_STDERR = 2'd2} cls_e;
  typedef struct packed {
    cls_e       cls;
    logic [7:0] len;
  } desc_t;
  typedef enum logic {ST_RUN = 1'b0, ST_ERROR = 1'b1} state_e;

  state_e         state_q, state_d;
  desc_t          desc_mem_q [MaxOutstanding];
  desc_t          desc_mem_d [MaxOutstanding];
  logic [DPW-1:0] desc_wr_q, desc_wr_d, desc_rd_q, desc_rd_d;
  logic [DCW-1:0] desc_cnt_q, desc_cnt_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [7:0]     char_mem_q [CharFifoDepth];
  logic [7:0]     char_mem_d [CharFifoDepth];
  logic [CPW-1:0] char_wr_q, char_wr_d, char_rd_q, char_rd_d;
  logic [CCW-1:0] char_cnt_q, char_cnt_d;
  logic           eoc_q, eoc_d;
  logic [31:0]    exit_q, exit_d;
  logic [15:0]    dropped_q, dropped_d;

  logic  aw_hs, w_hs, desc_empty, desc_full, bypass, have_desc, w_pop;
  logic  err_now, beat_ok, push_desc, pop_desc;
  logic  char_push, char_pop, char_full, char_wr, char_drop;
  desc_t new_desc, head_desc;

  // Error detection: any error freezes all decoding in that same cycle.
  always_comb begin
    aw_hs        = aw_valid_i & aw_ready_i;
    w_hs         = w_valid_i & w_ready_i;
    new_desc.len = aw_len_i;
    new_desc.cls = CLS_OTHER;
    if (aw_addr_i == StdoutAddr) new_desc.cls = CLS_STDOUT;
    else if (aw_addr_i == StderrAddr) new_desc.cls = CLS_STDERR;
    desc_empty = (desc_cnt_q == '0);
    desc_full  = (desc_cnt_q == DCW'(MaxOutstanding));
    bypass     = desc_empty & aw_hs;
    head_desc  = bypass ? new_desc : desc_mem_q[desc_rd_q];
    have_desc  = ~desc_empty | aw_hs;
    w_pop      = w_hs & have_desc & w_last_i;
    err_now    = (state_q == ST_RUN) &
                 ((w_hs & ~have_desc) |
                  (w_hs & have_desc & ((beat_cnt_q == head_desc.len) != w_last_i)) |
                  (aw_hs & desc_full & ~w_pop));
    beat_ok    = (state_q == ST_RUN) & ~err_now & w_hs;
    push_desc  = (state_q == ST_RUN) & ~err_now & aw_hs & ~(bypass & w_pop);
    pop_desc   = (state_q == ST_RUN) & ~err_now & w_pop & ~bypass;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && err_now) state_d = ST_ERROR;
  end

  always_comb begin
    desc_mem_d = desc_mem_q;
    desc_wr_d  = desc_wr_q;
    desc_rd_d  = desc_rd_q;
    if (push_desc) begin
      desc_mem_d[desc_wr_q] = new_desc;
      desc_wr_d             = desc_wr_q + DPW'(1);
    end
    if (pop_desc) desc_rd_d = desc_rd_q + DPW'(1);
    desc_cnt_d = desc_cnt_q + DCW'(push_desc) - DCW'(pop_desc);

    beat_cnt_d = beat_cnt_q;
    if (beat_ok) beat_cnt_d = w_last_i ? 8'd0 : beat_cnt_q + 8'd1;

    eoc_d  = eoc_q;
    exit_d = exit_q;
    if (beat_ok && head_desc.cls == CLS_STDERR && !eoc_q) begin
      eoc_d  = 1'b1;
      exit_d = w_data_i[31:0];
    end
  end

  // Character FIFO keeps draining even after an error.
  always_comb begin
    char_push  = beat_ok & (head_desc.cls == CLS_STDOUT) & w_strb_i[0];
    char_pop   = (char_cnt_q != '0) & char_ready_i;
    char_full  = (char_cnt_q == CCW'(CharFifoDepth));
    char_wr    = char_push & (~char_full | char_pop);
    char_drop  = char_push & char_full & ~char_pop;
    char_mem_d = char_mem_q;
    char_wr_d  = char_wr_q;
    char_rd_d  = char_rd_q;
    if (char_wr) begin
      char_mem_d[char_wr_q] = w_data_i[7:0];
      char_wr_d             = char_wr_q + CPW'(1);
    end
    if (char_pop) char_rd_d = char_rd_q + CPW'(1);
    char_cnt_d = char_cnt_q + CCW'(char_wr) - CCW'(char_pop);
    dropped_d  = dropped_q;
    if (char_drop && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      desc_mem_q <= '{default: '0};
      desc_wr_q  <= '0;
      desc_rd_q  <= '0;
      desc_cnt_q <= '0;
      beat_cnt_q <= '0;
      char_mem_q <= '{default: '0};
      char_wr_q  <= '0;
      char_rd_q  <= '0;
      char_cnt_q <= '0;
      eoc_q      <= 1'b0;
      exit_q     <= '0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      desc_mem_q <= desc_mem_d;
      desc_wr_q  <= desc_wr_d;
      desc_rd_q  <= desc_rd_d;
      desc_cnt_q <= desc_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      char_mem_q <= char_mem_d;
      char_wr_q  <= char_wr_d;
      char_rd_q  <= char_rd_d;
      char_cnt_q <= char_cnt_d;
      eoc_q      <= eoc_d;
      exit_q     <= exit_d;
      dropped_q  <= dropped_d;
    end
  end

  always_comb begin
    err_o         = (state_q == ST_ERROR);
    char_valid_o  = (char_cnt_q != '0);
    char_o        = char_valid_o ? char_mem_q[char_rd_q] : 8'h00;
    eoc_o         = eoc_q;
    exit_code_o   = exit_q;
    dropped_o     = dropped_q;
    outstanding_o = desc_cnt_q;
  end

endmodule
